// File: rtl/pll_seq_pkg.sv
// Shared state encoding and counter-width helper for the PLL reset sequencer.
`timescale 1ns/1ps
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } pll_seq_state_e;

  // Bits needed to hold every value 0..limit (never narrower than one bit).
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchroniser with asynchronous active-low reset.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: resets the PLL, waits for a debounced lock, then
// releases channel resets in staggered order; retries on timeout, faults when exhausted.
`timescale 1ns/1ps
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int LLC_W          = 8
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic                           sw_reset,
  output logic                           pll_rst,
  output logic [N_CH-1:0]                ch_rst_n,
  output logic                           ready,
  output logic                           fault,
  output logic [cnt_w(MAX_RETRIES)-1:0]  retry_count,
  output logic [LLC_W-1:0]               lock_loss_cnt,
  output logic [2:0]                     state
);

  localparam int REL_CYCLES = STAGGER_CYCLES * N_CH;
  localparam int PH_MAX     = (PLL_RST_CYCLES > REL_CYCLES) ? PLL_RST_CYCLES : REL_CYCLES;
  localparam int PH_W       = cnt_w(PH_MAX);
  localparam int TO_W       = cnt_w(LOCK_TIMEOUT);
  localparam int ST_W       = cnt_w(STABLE_CYCLES);
  localparam int RC_W       = cnt_w(MAX_RETRIES);

  pll_seq_state_e  state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;       // PLL_RST hold time, then RELEASE stagger time
  logic [TO_W-1:0] to_q, to_d;
  logic [ST_W-1:0] stab_q, stab_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [LLC_W-1:0] llc_q, llc_d;
  logic [N_CH-1:0] ch_q, ch_d;
  logic            pll_rst_q, ready_q, fault_q;
  logic            locked_s;
  logic            timeout;

  sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  assign timeout = (to_q == TO_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    to_d    = to_q;
    stab_d  = stab_q;
    rc_d    = rc_q;
    llc_d   = llc_q;
    ch_d    = ch_q;

    if (sw_reset) begin
      state_d = ST_PLL_RST;
      ph_d    = '0;
      to_d    = '0;
      stab_d  = '0;
      rc_d    = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (ph_q == PH_W'(PLL_RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            ph_d    = '0;
            to_d    = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          to_d = to_q + 1'b1;
          if (timeout) begin
            if (rc_q < RC_W'(MAX_RETRIES)) begin
              rc_d    = rc_q + 1'b1;
              state_d = ST_PLL_RST;
              ph_d    = '0;
            end else begin
              state_d = ST_FAULT;
            end
          end else if (locked_s) begin
            state_d = ST_STABLE;
            stab_d  = '0;
          end
        end
        ST_STABLE: begin
          to_d = to_q + 1'b1;
          // A release that completes on the timeout cycle still counts as success.
          if (locked_s && (stab_q == ST_W'(STABLE_CYCLES - 1))) begin
            state_d = ST_RELEASE;
            ph_d    = '0;
          end else if (timeout) begin
            if (rc_q < RC_W'(MAX_RETRIES)) begin
              rc_d    = rc_q + 1'b1;
              state_d = ST_PLL_RST;
              ph_d    = '0;
            end else begin
              state_d = ST_FAULT;
            end
          end else if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            ph_d    = '0;
            if (llc_q != '1) llc_d = llc_q + 1'b1;
          end else if (state_q == ST_RELEASE) begin
            ph_d = ph_q + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
              if (int'(ph_q) + 1 >= STAGGER_CYCLES * (i + 1)) ch_d[i] = 1'b1;
            end
            if (int'(ph_q) + 1 == REL_CYCLES) begin
              state_d = ST_RUN;
              rc_d    = '0;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_PLL_RST;
          ph_d    = '0;
        end
      endcase
    end

    // Channels are only ever out of reset while releasing or running.
    if ((state_d != ST_RELEASE) && (state_d != ST_RUN)) ch_d = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLL_RST;
      ph_q      <= '0;
      to_q      <= '0;
      stab_q    <= '0;
      rc_q      <= '0;
      llc_q     <= '0;
      ch_q      <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      to_q      <= to_d;
      stab_q    <= stab_d;
      rc_q      <= rc_d;
      llc_q     <= llc_d;
      ch_q      <= ch_d;
      pll_rst_q <= (state_d == ST_PLL_RST);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign ch_rst_n      = ch_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_count   = rc_q;
  assign lock_loss_cnt = llc_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised + directed bench for pll_reset_sequencer: a per-cycle behavioural
// model pushes expected outputs, a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int N_CH           = 3;
  localparam int PLL_RST_CYCLES = 4;
  localparam int STABLE_CYCLES  = 16;
  localparam int STAGGER_CYCLES = 2;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int MAX_RETRIES    = 2;
  localparam int LLC_W          = 8;
  localparam int RC_W           = 2;
  localparam int W              = 1 + N_CH + 1 + 1 + RC_W + LLC_W + 3;
  localparam int LLC_MAX        = (1 << LLC_W) - 1;

  localparam int S_PLL_RST = 0, S_WAIT_LOCK = 1, S_STABLE = 2;
  localparam int S_RELEASE = 3, S_RUN = 4, S_FAULT = 5;

  // ---------------- clock / reset / DUT ----------------
  logic            refclk = 1'b0;
  logic            rst_n;
  logic            pll_locked;
  logic            sw_reset;
  logic            pll_rst;
  logic [N_CH-1:0] ch_rst_n;
  logic            ready;
  logic            fault;
  logic [RC_W-1:0] retry_count;
  logic [LLC_W-1:0] lock_loss_cnt;
  logic [2:0]      state;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .N_CH           (N_CH),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .STAGGER_CYCLES (STAGGER_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES),
    .LLC_W          (LLC_W)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .sw_reset      (sw_reset),
    .pll_rst       (pll_rst),
    .ch_rst_n      (ch_rst_n),
    .ready         (ready),
    .fault         (fault),
    .retry_count   (retry_count),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  int m_state, m_t, m_wait_t, m_good, m_rel_t, m_retries, m_llc;
  bit m_p0, m_p1;   // pll_locked as seen 1 and 2 edges ago

  function automatic void model_reset();
    m_state = S_PLL_RST; m_t = 0; m_wait_t = 0; m_good = 0;
    m_rel_t = 0; m_retries = 0; m_llc = 0; m_p0 = 0; m_p1 = 0;
  endfunction

  function automatic void go_rst();
    m_state = S_PLL_RST;
    m_t     = 0;
  endfunction

  function automatic void attempt_failed();
    if (m_retries < MAX_RETRIES) begin
      m_retries++;
      go_rst();
    end else begin
      m_state = S_FAULT;
    end
  endfunction

  function automatic void lock_lost();
    if (m_llc < LLC_MAX) m_llc++;
    go_rst();
  endfunction

  // Advance the model by one refclk edge with the given inputs.
  function automatic void model_step(input bit lk, input bit sw);
    bit ls;
    ls   = m_p1;
    m_p1 = m_p0;
    m_p0 = lk;
    if (sw) begin
      go_rst();
      m_retries = 0;
    end else begin
      case (m_state)
        S_PLL_RST: begin
          m_t++;
          if (m_t == PLL_RST_CYCLES) begin m_state = S_WAIT_LOCK; m_wait_t = 0; end
        end
        S_WAIT_LOCK: begin
          m_wait_t++;
          if (m_wait_t == LOCK_TIMEOUT) attempt_failed();
          else if (ls) begin m_state = S_STABLE; m_good = 0; end
        end
        S_STABLE: begin
          m_wait_t++;
          if (ls) m_good++;
          if (ls && m_good == STABLE_CYCLES) begin m_state = S_RELEASE; m_rel_t = 0; end
          else if (m_wait_t == LOCK_TIMEOUT) attempt_failed();
          else if (!ls) m_state = S_WAIT_LOCK;
        end
        S_RELEASE: begin
          if (!ls) lock_lost();
          else begin
            m_rel_t++;
            if (m_rel_t == STAGGER_CYCLES * N_CH) begin m_state = S_RUN; m_retries = 0; end
          end
        end
        S_RUN: if (!ls) lock_lost();
        default: ;
      endcase
    end
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [N_CH-1:0] ch;
    ch = '0;
    if (m_state == S_RUN) ch = '1;
    else if (m_state == S_RELEASE)
      for (int i = 0; i < N_CH; i++) if (m_rel_t >= STAGGER_CYCLES * (i + 1)) ch[i] = 1'b1;
    return {(m_state == S_PLL_RST), ch, (m_state == S_RUN), (m_state == S_FAULT),
            RC_W'(m_retries), LLC_W'(m_llc), 3'(m_state)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: apply inputs, predict the post-edge outputs, wait one cycle.
  task automatic cycle(input bit lk, input bit sw);
    pll_locked = lk;
    sw_reset   = sw;
    model_step(lk, sw);
    exp_q.push_back(model_out());
    @(negedge refclk);
  endtask

  task automatic run_until(input int st, input int budget, input string name);
    int n;
    n = 0;
    while (m_state != st && n < budget) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    if (m_state != st) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: budget of %0d cycles expired in model state %0d", name, budget, m_state);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] act_vec;
  assign act_vec = {pll_rst, ch_rst_n, ready, fault, retry_count, lock_loss_cnt, state};

  always begin
    logic [W-1:0] e;
    @(posedge refclk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_vec !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got {pll_rst,ch,ready,fault,retry,llc,state}=%h expected %h",
                 $time, act_vec, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int saved_llc;
    int n;
    bit lk;
    int len;

    rst_n = 1'b1; pll_locked = 1'b0; sw_reset = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge refclk);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_ch_rst_n", ch_rst_n, 0);
    chk("reset_ready", ready, 0);
    chk("reset_fault", fault, 0);
    chk("reset_retry", retry_count, 0);
    chk("reset_llc", lock_loss_cnt, 0);
    chk("reset_state", state, S_PLL_RST);
    rst_n = 1'b1;

    // Clean bring-up, lock appears at cycle 10.
    for (int c = 0; c < 60; c++) cycle(c >= 10, 1'b0);
    chk("s1_ready", ready, 1);
    chk("s1_ch", ch_rst_n, 3'b111);
    chk("s1_retry", retry_count, 0);

    // Lock loss in RUN for 5 cycles.
    repeat (3) cycle(1'b0, 1'b0);
    chk("s3_ready_drop", ready, 0);
    chk("s3_ch_drop", ch_rst_n, 0);
    chk("s3_llc", lock_loss_cnt, 1);
    repeat (2) cycle(1'b0, 1'b0);
    run_until(S_RUN, 200, "s3_resequence");
    repeat (2) cycle(1'b1, 1'b0);
    chk("s3_ready_again", ready, 1);

    // Lock never arrives: retries then fault.
    cycle(1'b0, 1'b1);
    for (int c = 0; c < 215; c++) cycle(1'b0, 1'b0);
    chk("s2_fault", fault, 1);
    chk("s2_ch", ch_rst_n, 0);
    chk("s2_pll_rst", pll_rst, 0);
    chk("s2_retry", retry_count, MAX_RETRIES);
    chk("s2_state", state, S_FAULT);

    // sw_reset out of FAULT.
    saved_llc = m_llc;
    cycle(1'b0, 1'b1);
    chk("s5_state", state, S_PLL_RST);
    chk("s5_fault", fault, 0);
    chk("s5_retry", retry_count, 0);
    chk("s5_llc_kept", lock_loss_cnt, saved_llc);

    // Glitch during STABLE at stable count 10.
    run_until(S_STABLE, 100, "s4_reach_stable");
    n = 0;
    while (m_good < 10 && n < 100) begin cycle(1'b1, 1'b0); n++; end
    repeat (3) cycle(1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0);
    chk("s4_no_release", ch_rst_n, 0);
    run_until(S_RUN, 100, "s4_release");
    repeat (2) cycle(1'b1, 1'b0);
    chk("s4_ready", ready, 1);

    // sw_reset on the same edge that sees a RUN lock loss.
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    saved_llc = m_llc;
    cycle(1'b0, 1'b1);
    chk("s5b_llc_kept", lock_loss_cnt, saved_llc);
    chk("s5b_state", state, S_PLL_RST);

    // Random lock behaviour with sporadic sw_reset.
    for (int seg = 0; seg < 40; seg++) begin
      lk  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 90);
      for (int c = 0; c < len; c++) cycle(lk, $urandom_range(0, 63) == 0);
    end

    // 300 lock losses drive the counter into saturation.
    cycle(1'b1, 1'b1);
    for (int k = 0; k < 300; k++) begin
      n = 0;
      while (!(m_state == S_RELEASE || m_state == S_RUN) && n < 200) begin
        cycle(1'b1, 1'b0);
        n++;
      end
      if (n >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL s6_reach_release: budget expired at loss %0d", k);
      end
      repeat (3) cycle(1'b0, 1'b0);
    end
    chk("s6_llc_sat", lock_loss_cnt, LLC_MAX);

    // Asynchronous reset in the middle of RELEASE.
    run_until(S_RELEASE, 200, "s6_reach_release_final");
    repeat (2) cycle(1'b1, 1'b0);
    chk("s6_partial_release", ch_rst_n, 3'b001);
    @(posedge refclk);
    #3 rst_n = 1'b0;
    #1;
    chk("s6_async_pll_rst", pll_rst, 1);
    chk("s6_async_ch", ch_rst_n, 0);
    chk("s6_async_ready", ready, 0);
    chk("s6_async_fault", fault, 0);
    chk("s6_async_retry", retry_count, 0);
    chk("s6_async_llc", lock_loss_cnt, 0);
    chk("s6_async_state", state, S_PLL_RST);
    model_reset();
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) cycle(c >= 3, 1'b0);
    chk("s6_rerun_ready", ready, 1);

    @(posedge refclk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Parametrised reset and lock supervisor that runs on the PLL reference clock. It resets the fixed PLL and waits for a debounced lock. It then releases N_CH per-output-domain resets in staggered order. On lock loss or lock timeout it re-sequences, with bounded retries, a fault state and lock-loss statistics. It sits between board reset and every PLL-clocked datapath domain.

Parameters:
N_CH, 4, number of downstream channel resets (one per PLL output clock), 1..16
PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt, >=1
LOCK_TIMEOUT, 65536, max refclk cycles from WAIT_LOCK entry to end of STABLE before an attempt fails
STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before release
STAGGER_CYCLES, 8, refclk cycles between successive channel releases, >=1
MAX_RETRIES, 3, failed attempts allowed before FAULT
LLC_W, 8, width of the saturating lock-loss counter

Ports:
refclk  in  1  reference clock, the block's only clock
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked output, asynchronous to refclk
sw_reset  in  1  synchronous single-cycle restart request
pll_rst  out  1  active-high reset to the PLL
ch_rst_n  out  N_CH  active-low channel resets; each consumer synchronises its own bit into its own domain
ready  out  1  all channels released, PLL locked
fault  out  1  retries exhausted
retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts since last success or restart
lock_loss_cnt  out  LLC_W  saturating count of lock losses in RUN/RELEASE
state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset (rst_n low, asynchronous): state=PLL_RST, pll_rst=1, ch_rst_n=all 0, ready=0, fault=0, retry_count=0, lock_loss_cnt=0, synchroniser flops=0, counters=0.
- pll_locked passes through a 2-flop synchroniser (locked_s). It adds 2 cycles of latency. Every decision below uses locked_s only.
- All outputs are registered and change on the cycle after the state transition that causes them.
- PLL_RST: pll_rst=1 and all ch_rst_n=0. After PLL_RST_CYCLES cycles, go to WAIT_LOCK with pll_rst=0. The timeout counter clears on entry to WAIT_LOCK.
- WAIT_LOCK: the timeout counter increments every cycle. locked_s=1 sends the FSM to STABLE, with the stable counter cleared.
- STABLE: the timeout counter keeps running. The stable counter increments while locked_s=1. locked_s=0 sends the FSM back to WAIT_LOCK without clearing the timeout counter. When the stable counter reaches STABLE_CYCLES, go to RELEASE.
- Timeout: if the timeout counter reaches LOCK_TIMEOUT in WAIT_LOCK or STABLE:
  - retry_count < MAX_RETRIES: retry_count++, go to PLL_RST.
  - otherwise: go to FAULT.
- RELEASE: ch_rst_n[i] deasserts STAGGER_CYCLES*(i+1) cycles after RELEASE entry, channel 0 first. Released bits stay high. After channel N_CH-1 is released, go to RUN with ready=1 and retry_count cleared.
- RUN: hold. locked_s=0 in RUN or RELEASE counts as lock loss:
  - all ch_rst_n go 0 and ready goes 0 on the next cycle;
  - lock_loss_cnt increments, saturating at 2^LLC_W-1;
  - go to PLL_RST.
- FAULT: pll_rst=0, ch_rst_n=0, ready=0, fault=1. Exit only via sw_reset or rst_n.
- sw_reset: in any state, go to PLL_RST next cycle, clearing retry_count, fault and all counters. lock_loss_cnt is not cleared.
- sw_reset coinciding with a lock loss in the same cycle: sw_reset wins, and lock_loss_cnt does not increment.
- Timeout in the same cycle as the stable counter reaching STABLE_CYCLES: the release wins.
- Counter widths derive from $clog2 of their limits. There is no wrap-around.

Decomposition:
- Package pll_seq_pkg holds the state enum and its encodings (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5) and a width helper function.
- One sub-module, sync_2ff, is the generic bit synchroniser with asynchronous active-low reset, used for pll_locked.
- The FSM, the counters and the stagger logic stay in the top module.

Test Plan:
Bench parameters for all scenarios: N_CH=3, PLL_RST_CYCLES=4, STABLE_CYCLES=16, STAGGER_CYCLES=2, LOCK_TIMEOUT=64, MAX_RETRIES=2.
1. rst_n release, pll_locked high from cycle 10:
   - pll_rst high for cycles 0-3;
   - ch_rst_n goes 3'b001, then 3'b011, then 3'b111 at 2-cycle spacing after the 16 stable cycles;
   - ready=1; retry_count=0.
2. pll_locked held low:
   - three PLL_RST pulses with retry_count going 1, then 2;
   - fault=1 after the third timeout; all ch_rst_n=0; pll_rst=0.
3. In RUN, drop pll_locked for 5 cycles:
   - ch_rst_n=0 and ready=0 within 3 cycles (2 synchroniser + 1);
   - lock_loss_cnt=1; full re-sequence follows.
4. In STABLE, glitch pll_locked low for 3 cycles at stable count 10:
   - return to WAIT_LOCK with no release;
   - release after 16 further clean cycles, provided the timeout has not expired.
5. In FAULT, pulse sw_reset:
   - fault=0, retry_count=0, state=PLL_RST;
   - lock_loss_cnt unchanged.
   Separately, sw_reset in the same cycle as a RUN lock loss: lock_loss_cnt unchanged.
6. Force 300 lock losses with LLC_W=8: lock_loss_cnt saturates at 255. Then assert rst_n low mid-RELEASE: all outputs return to reset values immediately.
